// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register/check encodings, counter type and in-flight limit
`ifndef ALEN
`define ALEN 4:0
`endif
`ifndef NONE
`define NONE 2'b00
`endif
`ifndef RS1
`define RS1 2'b01
`endif
`ifndef RS2
`define RS2 2'b10
`endif
`ifndef RS1_RS2
`define RS1_RS2 2'b11
`endif

package reg_scoreboard_pkg;
    localparam int SB_MAX_INFLIGHT = 3;
    localparam int SB_CNT_W = $clog2(SB_MAX_INFLIGHT + 1);
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating up/down pending-write counter with clear, saturation flag and underflow pulse
module sb_counter #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         sat,
    output logic         uflow
);
    assign sat   = cnt == W'(MAX);
    assign uflow = dec & (cnt == '0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= clr ? '0 :
                   (inc & ~dec) ? cnt + W'(1) :
                   (dec & ~inc & ~uflow) ? cnt - W'(1) : cnt;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters answering ID-stage stall queries.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle final write-back clear the stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREGS        = 32,
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_issue_valid,
    input  logic             i_issue_wen,
    input  logic [`ALEN]     i_issue_rd,
    output logic             o_issue_ready,
    input  logic             i_wb_valid,
    input  logic [`ALEN]     i_wb_rd,
    input  logic             i_flush,
    input  logic [`ALEN]     i_rs1,
    input  logic [`ALEN]     i_rs2,
    input  logic [1:0]       i_check_regs,
    output logic             o_stall,
    output logic [NREGS-1:0] o_busy_vec,
    output logic             o_err_underflow
);
    logic             inc;
    logic             dec;
    logic [NREGS-1:0] sat;
    logic [NREGS-1:0] uflow;
    logic [NREGS-1:0] busy_src;
    logic [CNT_W-1:0] cnt [NREGS];

    assign inc = i_issue_valid & i_issue_wen & o_issue_ready & (i_issue_rd != '0);
    assign dec = i_wb_valid & (i_wb_rd != '0);

    // x0 is hardwired: never busy, never saturated
    assign cnt[0]        = '0;
    assign sat[0]        = 1'b0;
    assign uflow[0]      = 1'b0;
    assign o_busy_vec[0] = 1'b0;
    assign busy_src[0]   = 1'b0;

    generate
        for (genvar r = 1; r < NREGS; r++) begin : g_reg
            localparam logic [`ALEN] IDX = r;
            sb_counter #(.W(CNT_W), .MAX(MAX_INFLIGHT)) u_cnt (
                .clk  (i_clk),
                .rst_n(i_rst_n),
                .clr  (i_flush),
                .inc  (inc & (i_issue_rd == IDX)),
                .dec  (dec & (i_wb_rd == IDX)),
                .cnt  (cnt[r]),
                .sat  (sat[r]),
                .uflow(uflow[r])
            );
            assign o_busy_vec[r] = cnt[r] != '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
            // last pending write lands this cycle; regfile write-before-read covers the read
            assign busy_src[r] = o_busy_vec[r] & ~(dec & (i_wb_rd == IDX) & (cnt[r] == CNT_W'(1)));
`else
            assign busy_src[r] = o_busy_vec[r];
`endif
        end
    endgenerate

    assign o_issue_ready = ~sat[i_issue_rd];
    assign o_stall = (i_check_regs == `RS1)     ? busy_src[i_rs1] :
                     (i_check_regs == `RS2)     ? busy_src[i_rs2] :
                     (i_check_regs == `RS1_RS2) ? (busy_src[i_rs1] | busy_src[i_rs2]) : 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            o_err_underflow <= 1'b0;
        else
            o_err_underflow <= o_err_underflow | (dec & |uflow);
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors push expected outputs; a negedge monitor pops and compares.
module tb_reg_scoreboard;
    localparam logic [1:0] C_NONE = 2'b00, C_RS1 = 2'b01, C_RS2 = 2'b10, C_BOTH = 2'b11;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP_STALL = 1'b0;
`else
    localparam logic BYP_STALL = 1'b1;
`endif

    logic        clk = 0;
    logic        rst_n = 0;
    logic        issue_valid = 0, issue_wen = 0, wb_valid = 0, flush = 0;
    logic [4:0]  issue_rd = 0, wb_rd = 0, rs1 = 0, rs2 = 0;
    logic [1:0]  check_regs = 0;
    logic        issue_ready, stall, err_underflow;
    logic [31:0] busy_vec;

    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] busy;
        logic        ready;
        logic        err;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    reg_scoreboard dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_issue_valid(issue_valid), .i_issue_wen(issue_wen), .i_issue_rd(issue_rd),
        .o_issue_ready(issue_ready),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_flush(flush),
        .i_rs1(rs1), .i_rs2(rs2), .i_check_regs(check_regs),
        .o_stall(stall), .o_busy_vec(busy_vec), .o_err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string n, input string f, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", n, f, got, want);
        end
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.name, "stall", {31'b0, stall}, {31'b0, e.stall});
            cmp(e.name, "busy_vec", busy_vec, e.busy);
            cmp(e.name, "issue_ready", {31'b0, issue_ready}, {31'b0, e.ready});
            cmp(e.name, "err_underflow", {31'b0, err_underflow}, {31'b0, e.err});
        end

    // one cycle of stimulus; expected values are those seen before the next rising edge
    task automatic cyc(input string name, input logic rst, input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd, input logic fl,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [1:0] chk,
                       input logic e_stall, input logic [31:0] e_busy, input logic e_ready, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; issue_valid = iv; issue_wen = 1'b1; issue_rd = ird;
        wb_valid = wv; wb_rd = wrd; flush = fl; rs1 = s1; rs2 = s2; check_regs = chk;
        e.name = name; e.stall = e_stall; e.busy = e_busy; e.ready = e_ready; e.err = e_err;
        q.push_back(e);
    endtask

    localparam logic [31:0] B3 = 32'h1 << 3, B5 = 32'h1 << 5, B7 = 32'h1 << 7;
    localparam logic [31:0] B9 = 32'h1 << 9, B12 = 32'h1 << 12;

    initial begin
        //   name          rst iv ird wv wrd fl rs1 rs2 chk      stall busy ready err
        cyc("in_reset",    0, 1, 5,  0, 0,  0, 5,  0, C_RS1,  0, 0,   1, 0);
        cyc("idle",        1, 0, 0,  0, 0,  0, 0,  0, C_NONE, 0, 0,   1, 0);
        cyc("iss5",        1, 1, 5,  0, 0,  0, 5,  0, C_RS1,  0, 0,   1, 0);
        cyc("q5_a",        1, 0, 0,  0, 0,  0, 5,  0, C_RS1,  1, B5,  1, 0);
        cyc("q5_b",        1, 0, 0,  0, 0,  0, 5,  0, C_RS1,  1, B5,  1, 0);
        cyc("wb5",         1, 0, 0,  1, 5,  0, 5,  0, C_RS1,  BYP_STALL, B5, 1, 0);
        cyc("q5_clear",    1, 0, 0,  0, 0,  0, 5,  0, C_RS1,  0, 0,   1, 0);
        cyc("iss7_1",      1, 1, 7,  0, 0,  0, 0,  0, C_NONE, 0, 0,   1, 0);
        cyc("iss7_2",      1, 1, 7,  0, 0,  0, 0,  0, C_NONE, 0, B7,  1, 0);
        cyc("iss7_3",      1, 1, 7,  0, 0,  0, 0,  0, C_NONE, 0, B7,  1, 0);
        cyc("iss7_drop",   1, 1, 7,  0, 0,  0, 0,  7, C_RS2,  1, B7,  0, 0);
        cyc("wb7_1",       1, 0, 7,  1, 7,  0, 0,  0, C_NONE, 0, B7,  0, 0);
        cyc("wb7_2",       1, 0, 7,  1, 7,  0, 0,  0, C_NONE, 0, B7,  1, 0);
        cyc("wb7_3",       1, 0, 0,  1, 7,  0, 7,  0, C_RS1,  BYP_STALL, B7, 1, 0);
        cyc("q7_clear",    1, 0, 0,  0, 0,  0, 7,  0, C_RS1,  0, 0,   1, 0);
        cyc("iss9",        1, 1, 9,  0, 0,  0, 0,  0, C_NONE, 0, 0,   1, 0);
        cyc("iss9_wb9",    1, 1, 9,  1, 9,  0, 0,  0, C_NONE, 0, B9,  1, 0);
        cyc("q9_held",     1, 0, 0,  0, 0,  0, 0,  9, C_BOTH, 1, B9,  1, 0);
        cyc("wb9",         1, 0, 0,  1, 9,  0, 0,  0, C_NONE, 0, B9,  1, 0);
        cyc("iss0",        1, 1, 0,  0, 0,  0, 0,  0, C_RS2,  0, 0,   1, 0);
        cyc("q0",          1, 0, 0,  0, 0,  0, 0,  0, C_RS2,  0, 0,   1, 0);
        cyc("iss3_1",      1, 1, 3,  0, 0,  0, 0,  0, C_NONE, 0, 0,   1, 0);
        cyc("iss3_2",      1, 1, 3,  0, 0,  0, 0,  0, C_NONE, 0, B3,  1, 0);
        cyc("flush_iss3",  1, 1, 3,  0, 0,  1, 3,  0, C_RS1,  1, B3,  1, 0);
        cyc("post_flush",  1, 0, 0,  0, 0,  0, 3,  0, C_RS1,  0, 0,   1, 0);
        cyc("wb3_empty",   1, 0, 0,  1, 3,  0, 0,  0, C_NONE, 0, 0,   1, 0);
        cyc("uflow_set",   1, 1, 12, 0, 0,  0, 0,  0, C_NONE, 0, 0,   1, 1);
        cyc("uflow_stick", 1, 0, 0,  0, 0,  0, 12, 0, C_RS1,  1, B12, 1, 1);
        cyc("async_rst",   0, 0, 0,  0, 0,  0, 12, 0, C_RS1,  0, 0,   1, 0);
        cyc("after_rst",   1, 0, 0,  0, 0,  0, 12, 0, C_RS1,  0, 0,   1, 0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer-side hazard tracker for the in-order RISC-V pipeline.
- Per architectural register, counts in-flight writes: incremented when an instruction with a destination leaves ID, decremented when its result retires at WB.
- Answers ID-stage source queries with a stall request.
- Supports long-latency producers (loads, multi-cycle units) whose rd is no longer visible in the EXE/MEM rd fields.

Parameters:
- NREGS, 32, number of architectural registers (x0 to x31).
- MAX_INFLIGHT, 3, maximum outstanding writes tracked per register.
- CNT_W, $clog2(MAX_INFLIGHT+1), width of each pending counter.

Ports:
- i_clk  input  1  core clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_issue_valid  input  1  ID hands an instruction to EXE this cycle.
- i_issue_wen  input  1  issuing instruction writes a register.
- i_issue_rd  input  `ALEN  destination of issuing instruction.
- o_issue_ready  output  1  low when the rd counter is saturated.
- i_wb_valid  input  1  an instruction writes the register file this cycle.
- i_wb_rd  input  `ALEN  destination being written back.
- i_flush  input  1  pipeline flush (branch mispredict / trap).
- i_rs1  input  `ALEN  ID source 1.
- i_rs2  input  `ALEN  ID source 2.
- i_check_regs  input  2  `NONE / `RS1 / `RS2 / `RS1_RS2.
- o_stall  output  1  source operand has a pending write.
- o_busy_vec  output  NREGS  bit r set when counter r is non-zero.
- o_err_underflow  output  1  sticky: write-back seen with no pending write.

Behaviour:
- State is cnt[r], CNT_W bits for r = 1..NREGS-1.
  - x0 is never tracked: cnt[0] is constant 0.
  - Issues and write-backs to x0 are ignored.
- Reset (asynchronous, i_rst_n low): all cnt = 0 and o_err_underflow = 0. Outputs follow immediately:
  - o_stall = 0
  - o_busy_vec = 0
  - o_issue_ready = 1
- Issue event is `inc = i_issue_valid & i_issue_wen & o_issue_ready & (i_issue_rd != 0)`.
- o_issue_ready is combinational: it is 0 when cnt[i_issue_rd] == MAX_INFLIGHT.
  - If i_issue_valid is high while o_issue_ready is low, the issue is dropped and the counter does not change.
  - The ID stage must hold the instruction until o_issue_ready is high.
- Write-back event is `dec = i_wb_valid & (i_wb_rd != 0)`.
- Counter update at the clock edge, per register:
  - inc only: cnt+1.
  - dec only: cnt-1.
  - inc and dec on the same register in the same cycle: unchanged.
  - inc and dec on different registers: both updates apply.
- Underflow: dec with cnt == 0 leaves cnt at 0 and sets o_err_underflow. It stays set until reset.
- Flush:
  - On the next edge, all cnt are cleared to 0, overriding any inc or dec in the same cycle.
  - o_err_underflow is not cleared.
  - Write-backs in the cycle after the flush apply normally, which may set underflow. The pipeline must squash WB for flushed instructions.
- Stall (combinational from current state):
  - `NONE`: o_stall = 0.
  - `RS1`: o_stall = busy(i_rs1).
  - `RS2`: o_stall = busy(i_rs2).
  - `RS1_RS2`: o_stall = busy(i_rs1) | busy(i_rs2).
  - busy(0) = 0 always.
- Latency:
  - An issue in cycle N is visible to o_stall in cycle N+1.
  - A write-back in cycle N clears busy in cycle N+1 when cnt was 1, unless the optional feature below is enabled.
- o_stall and o_busy_vec reflect state only. They never depend on i_issue_*.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: busy(r) = (cnt[r] != 0) & ~(dec & i_wb_rd == r & cnt[r] == 1). A source written back in the current cycle does not stall, which relies on register-file write-before-read. o_busy_vec stays state-only.
- Undefined: busy(r) = (cnt[r] != 0), giving one extra stall cycle on write-back.

Decomposition:
- Shared package:
  - Existing `ALEN and `NONE / `RS1 / `RS2 / `RS1_RS2 encodings.
  - New typedef `sb_cnt_t` (CNT_W bits).
  - Constant SB_MAX_INFLIGHT.
- Sub-module `sb_counter` is natural: one saturating up/down counter with clear, inc, dec, a sat flag and an underflow pulse, instantiated NREGS-1 times in a generate loop.
- Top level holds decode, the stall mux, the sticky error flag and the ready mux.

Test Plan:
- Reset then idle: o_stall = 0, o_busy_vec = 0, o_issue_ready = 1, o_err_underflow = 0.
- Issue rd=5 at cycle 1, then ID queries rs1=5 with `RS1` → o_stall = 1 at cycle 2. WB rd=5 at cycle 4 → o_stall = 0 at cycle 5, or at cycle 4 with SCOREBOARD_WB_BYPASS_EN.
- Issue rd=7 three times → cnt = 3, o_issue_ready = 0 for rd=7. A fourth issue is dropped. Three WBs are needed to clear bit 7.
- Same-cycle issue rd=9 and WB rd=9 with cnt = 1 → cnt stays 1 and o_busy_vec[9] = 1.
- Issue rd=0 and query rs2=0 with `RS2` → o_stall = 0 and o_busy_vec = 0.
- Flush with cnt[3] = 2 and a simultaneous issue rd=3 → o_busy_vec = 0 next cycle.
- WB rd=3 on an empty counter → o_err_underflow = 1 and stays 1 until reset; async reset mid-run clears all state immediately.
